sram_arb_ctrl: RTL and testbench

- Sequences the `sel` input of the synchronous SRAM arbiter between the SOPC (Avalon) master and the test-runner master.
- The SRAM datapath registers address, OE and readdataready one cycle after issue, so an unsafe `sel` flip misroutes in-flight read data. This block inserts a drain window before every ownership change.
- Enforces a fairness hold limit and honours a test-runner lock for burst capture.
- The top level ORs `sopc_stall`/`tr_stall` into the respective waitrequests.

---
 rtl/sram_arb_pkg.sv | 23 ++
 rtl/sram_arb_stats.sv | 39 +++
 rtl/sram_arb_ctrl.sv | 120 ++++++++++++
 tb/tb_sram_arb_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM ownership sequencer.
// Used by sram_arb_ctrl and the optional statistics block (SRAM_ARB_STATS_EN).
package sram_arb_pkg;

    typedef enum logic [1:0] {
        S_SOPC       = 2'd0,
        S_DRAIN_TR   = 2'd1,
        S_TR         = 2'd2,
        S_DRAIN_SOPC = 2'd3
    } state_e;

    localparam logic SEL_SOPC = 1'b0;
    localparam logic SEL_TR   = 1'b1;

    localparam int DEF_DRAIN_CYCLES = 2;
    localparam int DEF_MAX_HOLD     = 64;
    localparam int DEF_CNT_WIDTH    = 8;

    function automatic logic is_drain(state_e s);
        return (s == S_DRAIN_TR) || (s == S_DRAIN_SOPC);
    endfunction

endpackage

// File: rtl/sram_arb_stats.sv
// Switch statistics: drain-entry count (wrapping) and drain-cycle count (saturating).
// Instantiated by sram_arb_ctrl only when SRAM_ARB_STATS_EN is defined.
module sram_arb_stats (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        drain_entry,
    input  logic        switching,
    output logic [15:0] switch_cnt,
    output logic [31:0] stall_cycles
);

    logic [15:0] switch_cnt_q, switch_cnt_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        switch_cnt_d   = switch_cnt_q;
        stall_cycles_d = stall_cycles_q;
        if (drain_entry) begin
            switch_cnt_d = switch_cnt_q + 16'd1;
        end
        if (switching && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            switch_cnt_q   <= 16'd0;
            stall_cycles_q <= 32'd0;
        end else begin
            switch_cnt_q   <= switch_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign switch_cnt   = switch_cnt_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: rtl/sram_arb_ctrl.sv
// Sequences the SRAM arbiter sel between SOPC and test runner with a drain window,
// hold-limit fairness and test-runner lock. Optional stats ports: SRAM_ARB_STATS_EN.
module sram_arb_ctrl
    import sram_arb_pkg::*;
#(
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int MAX_HOLD     = DEF_MAX_HOLD,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sopc_read,
    input  logic        sopc_write,
    input  logic        tr_read,
    input  logic        tr_write,
    input  logic        tr_lock,
    output logic        sel,
    output logic        sopc_stall,
    output logic        tr_stall,
    output logic        tr_locked,
    output logic        switching,
    output state_e      dbg_state
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [15:0] switch_cnt,
    output logic [31:0] stall_cycles
`endif
);

    localparam logic [CNT_WIDTH-1:0] HOLD_MAX   = CNT_WIDTH'(MAX_HOLD);
    localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(DRAIN_CYCLES - 1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_WIDTH-1:0] drain_cnt_q, drain_cnt_d;
    logic                 sel_q, sel_d;
    logic                 switching_q, switching_d;
    logic                 tr_locked_q, tr_locked_d;
    logic                 sopc_req, tr_req, other_req;

    assign sopc_req = sopc_read | sopc_write;
    assign tr_req   = tr_read | tr_write | tr_lock;

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        drain_cnt_d = drain_cnt_q;
        other_req   = 1'b0;

        case (state_q)
            S_SOPC: begin
                other_req = tr_req;
                if (tr_req && (!sopc_req || hold_cnt_q == HOLD_MAX)) state_d = S_DRAIN_TR;
            end
            S_TR: begin
                other_req = sopc_req;
                if (sopc_req && !tr_lock && (!tr_req || hold_cnt_q == HOLD_MAX))
                    state_d = S_DRAIN_SOPC;
            end
            S_DRAIN_TR:   if (drain_cnt_q == DRAIN_LAST) state_d = S_TR;
            S_DRAIN_SOPC: if (drain_cnt_q == DRAIN_LAST) state_d = S_SOPC;
            default:      state_d = S_SOPC;
        endcase

        // Hold counter only runs while settled in an owner state with the other side waiting.
        if (is_drain(state_d)) begin
            hold_cnt_d  = '0;
            drain_cnt_d = is_drain(state_q) ? drain_cnt_q + 1'b1 : '0;
        end else begin
            drain_cnt_d = '0;
            if ((state_d != state_q) || !other_req) begin
                hold_cnt_d = '0;
            end else if (hold_cnt_q != HOLD_MAX) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end

        // Outputs are registered from the next state so they align with state_q.
        sel_d       = ((state_d == S_TR) || (state_d == S_DRAIN_SOPC)) ? SEL_TR : SEL_SOPC;
        switching_d = is_drain(state_d);
        tr_locked_d = (state_d == S_TR) && tr_lock;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_SOPC;
            hold_cnt_q  <= '0;
            drain_cnt_q <= '0;
            sel_q       <= SEL_SOPC;
            switching_q <= 1'b0;
            tr_locked_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            sel_q       <= sel_d;
            switching_q <= switching_d;
            tr_locked_q <= tr_locked_d;
        end
    end

    assign sel        = sel_q;
    assign switching  = switching_q;
    assign sopc_stall = switching_q;
    assign tr_stall   = switching_q;
    assign tr_locked  = tr_locked_q;
    assign dbg_state  = state_q;

`ifdef SRAM_ARB_STATS_EN
    sram_arb_stats u_stats (
        .clock        (clock),
        .reset_n      (reset_n),
        .drain_entry  (is_drain(state_d) && !is_drain(state_q)),
        .switching    (switching_q),
        .switch_cnt   (switch_cnt),
        .stall_cycles (stall_cycles)
    );
`endif

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Directed bench for sram_arb_ctrl (MAX_HOLD=4, DRAIN_CYCLES=2).
// Statistics checks are compiled in when SRAM_ARB_STATS_EN is defined.
module tb_sram_arb_ctrl;
    import sram_arb_pkg::*;

    logic   clock = 1'b0;
    logic   reset_n;
    logic   sopc_read, sopc_write, tr_read, tr_write, tr_lock;
    logic   sel, sopc_stall, tr_stall, tr_locked, switching;
    state_e dbg_state;
`ifdef SRAM_ARB_STATS_EN
    logic [15:0] switch_cnt;
    logic [31:0] stall_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    sram_arb_ctrl #(.DRAIN_CYCLES(2), .MAX_HOLD(4), .CNT_WIDTH(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .sopc_read  (sopc_read),
        .sopc_write (sopc_write),
        .tr_read    (tr_read),
        .tr_write   (tr_write),
        .tr_lock    (tr_lock),
        .sel        (sel),
        .sopc_stall (sopc_stall),
        .tr_stall   (tr_stall),
        .tr_locked  (tr_locked),
        .switching  (switching),
        .dbg_state  (dbg_state)
`ifdef SRAM_ARB_STATS_EN
        ,
        .switch_cnt   (switch_cnt),
        .stall_cycles (stall_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks sel, switching, both stalls, tr_locked and state together.
    task automatic chk_out(input string tag, input logic e_sel, input logic e_sw,
                           input logic e_lk, input state_e e_st);
        chk({tag, ".sel"},        32'(sel),        32'(e_sel));
        chk({tag, ".switching"},  32'(switching),  32'(e_sw));
        chk({tag, ".sopc_stall"}, 32'(sopc_stall), 32'(e_sw));
        chk({tag, ".tr_stall"},   32'(tr_stall),   32'(e_sw));
        chk({tag, ".tr_locked"},  32'(tr_locked),  32'(e_lk));
        chk({tag, ".state"},      32'(dbg_state),  32'(e_st));
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0;
        {sopc_read, sopc_write, tr_read, tr_write, tr_lock} = '0;
        step();
        step();
        chk_out("in_reset", 1'b0, 1'b0, 1'b0, S_SOPC);
        reset_n = 1'b1;

        // Idle after reset: parked on SOPC.
        for (int i = 0; i < 20; i++) begin
            step();
            chk_out("idle", 1'b0, 1'b0, 1'b0, S_SOPC);
        end

        // SOPC read, then a one-cycle tr_read pulse: drain 2 cycles with sel held at 0.
        sopc_read = 1'b1;
        step();
        chk_out("sopc_rd", 1'b0, 1'b0, 1'b0, S_SOPC);
        sopc_read = 1'b0;
        tr_read   = 1'b1;
        step();
        chk_out("drain_tr0", 1'b0, 1'b1, 1'b0, S_DRAIN_TR);
        tr_read = 1'b0;
        step();
        chk_out("drain_tr1", 1'b0, 1'b1, 1'b0, S_DRAIN_TR);
        step();
        chk_out("own_tr", 1'b1, 1'b0, 1'b0, S_TR);
        step();
        chk_out("park_tr", 1'b1, 1'b0, 1'b0, S_TR);

        // Lock held against a persistent SOPC write.
        tr_lock    = 1'b1;
        sopc_write = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (i % 20 == 0) chk_out("locked", 1'b1, 1'b0, 1'b1, S_TR);
        end
        step();
        chk_out("locked_end", 1'b1, 1'b0, 1'b1, S_TR);
        tr_lock = 1'b0;
        step();
        chk_out("drain_sopc0", 1'b1, 1'b1, 1'b0, S_DRAIN_SOPC);
        step();
        chk_out("drain_sopc1", 1'b1, 1'b1, 1'b0, S_DRAIN_SOPC);
        step();
        chk_out("own_sopc", 1'b0, 1'b0, 1'b0, S_SOPC);

        // Fairness: SOPC busy, tr_write waits; drain on the 5th waiting edge.
        tr_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("hold_sopc", 1'b0, 1'b0, 1'b0, S_SOPC);
        end
        step();
        chk_out("hold_drain0", 1'b0, 1'b1, 1'b0, S_DRAIN_TR);
        step();
        chk_out("hold_drain1", 1'b0, 1'b1, 1'b0, S_DRAIN_TR);
        step();
        chk_out("hold_own_tr", 1'b1, 1'b0, 1'b0, S_TR);

        // Symmetric preemption of TR, then reset in the middle of the drain.
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("hold_tr", 1'b1, 1'b0, 1'b0, S_TR);
        end
        step();
        chk_out("pre_reset_drain", 1'b1, 1'b1, 1'b0, S_DRAIN_SOPC);
        #2 reset_n = 1'b0;
        #1 chk_out("async_reset", 1'b0, 1'b0, 1'b0, S_SOPC);
        {sopc_read, sopc_write, tr_read, tr_write, tr_lock} = '0;
        step();
        reset_n = 1'b1;
        step();
        chk_out("post_reset", 1'b0, 1'b0, 1'b0, S_SOPC);

`ifdef SRAM_ARB_STATS_EN
        chk("stats_rst.switch_cnt", 32'(switch_cnt), 32'd0);
        chk("stats_rst.stall_cycles", stall_cycles, 32'd0);
        for (int t = 0; t < 3; t++) begin
            tr_read = 1'b1;
            step();
            tr_read = 1'b0;
            step();
            step();
            sopc_read = 1'b1;
            step();
            sopc_read = 1'b0;
            step();
            step();
        end
        step();
        chk("stats.switch_cnt", 32'(switch_cnt), 32'd6);
        chk("stats.stall_cycles", stall_cycles, 32'd12);
        chk_out("stats_end", 1'b0, 1'b0, 1'b0, S_SOPC);
`endif

        // Simultaneous requests below the hold limit: SOPC keeps the SRAM.
        sopc_read = 1'b1;
        tr_read   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("simul", 1'b0, 1'b0, 1'b0, S_SOPC);
        end
        sopc_read = 1'b0;
        tr_read   = 1'b0;
        step();
        chk_out("simul_idle", 1'b0, 1'b0, 1'b0, S_SOPC);

        // tr_lock alone counts as a request and yields a locked TR ownership.
        tr_lock = 1'b1;
        step();
        chk_out("lock_req0", 1'b0, 1'b1, 1'b0, S_DRAIN_TR);
        step();
        chk_out("lock_req1", 1'b0, 1'b1, 1'b0, S_DRAIN_TR);
        step();
        chk_out("lock_own", 1'b1, 1'b0, 1'b1, S_TR);
        tr_lock = 1'b0;
        step();
        chk_out("unlock_park", 1'b1, 1'b0, 1'b0, S_TR);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
